// File: rtl/bcd7seg_decoder.sv
// Registered 4-bit to seven-segment decoder for one board HEX digit, with
// blank / lamp-test overrides and a registered "legal BCD" flag.
module bcd7seg_decoder #(
  parameter int HEX_MODE   = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [0:6] seg,
  output logic       digit_ok
);

  localparam logic [0:6] LIT_OFF = 7'b0000000;
  localparam logic [0:6] LIT_ALL = 7'b1111111;

  logic [0:6] w_lit;
  logic [0:6] w_pattern;
  logic [0:6] w_drive;
  logic [0:6] w_drive_off;
  logic [0:6] r_seg;
  logic       r_digit_ok;

  // Bit order is a..g, matching seg[0]=a .. seg[6]=g.
  always_comb begin
    // NOTE: default first so every path assigns w_lit and no latch is inferred.
    w_lit = LIT_OFF;
    case (digit)
      4'd0:  w_lit = 7'b1111110;
      4'd1:  w_lit = 7'b0110000;
      4'd2:  w_lit = 7'b1101101;
      4'd3:  w_lit = 7'b1111001;
      4'd4:  w_lit = 7'b0110011;
      4'd5:  w_lit = 7'b1011011;
      4'd6:  w_lit = 7'b1011111;
      4'd7:  w_lit = 7'b1110000;
      4'd8:  w_lit = 7'b1111111;
      4'd9:  w_lit = 7'b1111011;
      4'd10: w_lit = (HEX_MODE != 0) ? 7'b1110111 : LIT_OFF;
      4'd11: w_lit = (HEX_MODE != 0) ? 7'b0011111 : LIT_OFF;
      4'd12: w_lit = (HEX_MODE != 0) ? 7'b1001110 : LIT_OFF;
      4'd13: w_lit = (HEX_MODE != 0) ? 7'b0111101 : LIT_OFF;
      4'd14: w_lit = (HEX_MODE != 0) ? 7'b1001111 : LIT_OFF;
      4'd15: w_lit = (HEX_MODE != 0) ? 7'b1000111 : LIT_OFF;
      default: w_lit = LIT_OFF;
    endcase
  end

  // Lamp test outranks blank; both outrank the decoded value.
  assign w_pattern   = lamp_test ? LIT_ALL : (blank ? LIT_OFF : w_lit);
  assign w_drive     = (ACTIVE_LOW != 0) ? ~w_pattern : w_pattern;
  assign w_drive_off = (ACTIVE_LOW != 0) ? ~LIT_OFF   : LIT_OFF;

  always_ff @(posedge ADC_CLK_10) begin
    // NOTE: non-blocking assignments for registered state avoid read/write races.
    if (reset) begin
      r_seg      <= w_drive_off;
      r_digit_ok <= 1'b0;
    end else begin
      r_seg      <= w_drive;
      r_digit_ok <= (digit <= 4'd9);
    end
  end

  assign seg      = r_seg;
  assign digit_ok = r_digit_ok;

endmodule

// File: tb/tb_bcd7seg_decoder.sv
// Self-checking bench: vector table, hand-written reset/latency/polarity
// sequences and random stimulus against a table-based reference model.
module tb_bcd7seg_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] digit;
  logic       blank;
  logic       lamp_test;
  logic [0:6] seg_dec, seg_hex, seg_pos;
  logic       ok_dec, ok_hex, ok_pos;

  int n_pass  = 0;
  int n_total = 0;

  bcd7seg_decoder #(.HEX_MODE(0), .ACTIVE_LOW(1)) dut (
    .ADC_CLK_10(clk), .reset(reset), .digit(digit), .blank(blank),
    .lamp_test(lamp_test), .seg(seg_dec), .digit_ok(ok_dec));

  bcd7seg_decoder #(.HEX_MODE(1), .ACTIVE_LOW(1)) dut_hex (
    .ADC_CLK_10(clk), .reset(reset), .digit(digit), .blank(blank),
    .lamp_test(lamp_test), .seg(seg_hex), .digit_ok(ok_hex));

  bcd7seg_decoder #(.HEX_MODE(0), .ACTIVE_LOW(0)) dut_pos (
    .ADC_CLK_10(clk), .reset(reset), .digit(digit), .blank(blank),
    .lamp_test(lamp_test), .seg(seg_pos), .digit_ok(ok_pos));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit patterns a..g straight from the digit/letter table.
  localparam logic [6:0] LIT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  function automatic logic [6:0] model_seg(input logic rst, input logic [3:0] d,
                                           input logic b, input logic lt,
                                           input bit hex, input bit al);
    logic [6:0] lit;
    if (rst)                       lit = 7'b0000000;
    else if (lt)                   lit = 7'b1111111;
    else if (b)                    lit = 7'b0000000;
    else if (int'(d) > 9 && !hex)  lit = 7'b0000000;
    else                           lit = LIT[d];
    return al ? ~lit : lit;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] d;
    logic       b;
    logic       lt;
    logic [6:0] exp_dec;
    logic [6:0] exp_hex;
    logic       exp_ok;
  } vec_t;

  vec_t vecs [22];

  initial begin
    vecs[0]  = '{4'd0,  1'b0, 1'b0, 7'b0000001, 7'b0000001, 1'b1};
    vecs[1]  = '{4'd1,  1'b0, 1'b0, 7'b1001111, 7'b1001111, 1'b1};
    vecs[2]  = '{4'd2,  1'b0, 1'b0, 7'b0010010, 7'b0010010, 1'b1};
    vecs[3]  = '{4'd3,  1'b0, 1'b0, 7'b0000110, 7'b0000110, 1'b1};
    vecs[4]  = '{4'd4,  1'b0, 1'b0, 7'b1001100, 7'b1001100, 1'b1};
    vecs[5]  = '{4'd5,  1'b0, 1'b0, 7'b0100100, 7'b0100100, 1'b1};
    vecs[6]  = '{4'd6,  1'b0, 1'b0, 7'b0100000, 7'b0100000, 1'b1};
    vecs[7]  = '{4'd7,  1'b0, 1'b0, 7'b0001111, 7'b0001111, 1'b1};
    vecs[8]  = '{4'd8,  1'b0, 1'b0, 7'b0000000, 7'b0000000, 1'b1};
    vecs[9]  = '{4'd9,  1'b0, 1'b0, 7'b0000100, 7'b0000100, 1'b1};
    vecs[10] = '{4'd10, 1'b0, 1'b0, 7'b1111111, 7'b0001000, 1'b0};
    vecs[11] = '{4'd11, 1'b0, 1'b0, 7'b1111111, 7'b1100000, 1'b0};
    vecs[12] = '{4'd12, 1'b0, 1'b0, 7'b1111111, 7'b0110001, 1'b0};
    vecs[13] = '{4'd13, 1'b0, 1'b0, 7'b1111111, 7'b1000010, 1'b0};
    vecs[14] = '{4'd14, 1'b0, 1'b0, 7'b1111111, 7'b0110000, 1'b0};
    vecs[15] = '{4'd15, 1'b0, 1'b0, 7'b1111111, 7'b0111000, 1'b0};
    vecs[16] = '{4'd3,  1'b1, 1'b0, 7'b1111111, 7'b1111111, 1'b1};
    vecs[17] = '{4'd3,  1'b0, 1'b1, 7'b0000000, 7'b0000000, 1'b1};
    vecs[18] = '{4'd3,  1'b1, 1'b1, 7'b0000000, 7'b0000000, 1'b1};
    vecs[19] = '{4'd12, 1'b0, 1'b1, 7'b0000000, 7'b0000000, 1'b0};
    vecs[20] = '{4'd14, 1'b1, 1'b0, 7'b1111111, 7'b1111111, 1'b0};
    vecs[21] = '{4'd9,  1'b1, 1'b1, 7'b0000000, 7'b0000000, 1'b1};

    reset = 1'b1; digit = 4'd8; blank = 1'b0; lamp_test = 1'b1;

    // Reset wins over lamp test.
    step();
    step();
    check("reset_seg", seg_dec, 7'b1111111);
    check("reset_ok", {6'b0, ok_dec}, 7'd0);
    check("reset_seg_pos", seg_pos, 7'b0000000);
    reset = 1'b0; lamp_test = 1'b0;
    step();
    check("first_decode_seg", seg_dec, 7'b0000000);
    check("first_decode_ok", {6'b0, ok_dec}, 7'd1);

    foreach (vecs[i]) begin
      digit = vecs[i].d; blank = vecs[i].b; lamp_test = vecs[i].lt;
      step();
      check($sformatf("vec%0d_dec", i), seg_dec, vecs[i].exp_dec);
      check($sformatf("vec%0d_hex", i), seg_hex, vecs[i].exp_hex);
      check($sformatf("vec%0d_ok", i), {6'b0, ok_dec}, {6'b0, vecs[i].exp_ok});
      check($sformatf("vec%0d_okhex", i), {6'b0, ok_hex}, {6'b0, vecs[i].exp_ok});
    end

    // Positive polarity and its reset value.
    digit = 4'd2; blank = 1'b0; lamp_test = 1'b0;
    step();
    check("pos_digit2", seg_pos, 7'b1101101);
    reset = 1'b1;
    step();
    check("pos_reset", seg_pos, 7'b0000000);
    check("pos_reset_ok", {6'b0, ok_pos}, 7'd0);
    reset = 1'b0;

    // Latency: a change between edges is invisible until the next edge.
    digit = 4'd4;
    step();
    check("lat_4", seg_dec, 7'b1001100);
    digit = 4'd7;
    #3;
    check("lat_hold_4", seg_dec, 7'b1001100);
    step();
    check("lat_7", seg_dec, 7'b0001111);

    // Mid-operation reset with lamp test and hex digit present.
    digit = 4'd11; lamp_test = 1'b1; reset = 1'b1;
    step();
    check("mid_reset_hex", seg_hex, 7'b1111111);
    check("mid_reset_ok", {6'b0, ok_hex}, 7'd0);
    reset = 1'b0; lamp_test = 1'b0;

    for (int n = 0; n < 400; n++) begin
      logic       r_rst, r_b, r_lt;
      logic [3:0] r_d;
      r_rst = ($urandom_range(15) == 0);
      r_d   = 4'($urandom_range(15));
      r_b   = ($urandom_range(3) == 0);
      r_lt  = ($urandom_range(5) == 0);
      reset = r_rst; digit = r_d; blank = r_b; lamp_test = r_lt;
      step();
      check("rand_dec", seg_dec, model_seg(r_rst, r_d, r_b, r_lt, 1'b0, 1'b1));
      check("rand_hex", seg_hex, model_seg(r_rst, r_d, r_b, r_lt, 1'b1, 1'b1));
      check("rand_pos", seg_pos, model_seg(r_rst, r_d, r_b, r_lt, 1'b0, 1'b0));
      check("rand_ok", {6'b0, ok_dec}, {6'b0, (!r_rst && int'(r_d) <= 9)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
